// File: rtl/regfile_mp.sv
// Multi-port integer register file: NRD combinational reads, prioritised ALU/load write-back, pending-write scoreboard.
// Optional same-cycle write-to-read bypass when REGFILE_BYPASS_EN is defined; otherwise reads see only the array.
module regfile_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NRD*$clog2(NREGS)-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]             rd_data,
  output logic [NRD-1:0]                  rd_busy,
  input  logic                            wa_en,
  input  logic [$clog2(NREGS)-1:0]        wa_addr,
  input  logic [XLEN-1:0]                 wa_data,
  input  logic                            wb_en,
  input  logic [$clog2(NREGS)-1:0]        wb_addr,
  input  logic [XLEN-1:0]                 wb_data,
  input  logic                            iss_en,
  input  logic [$clog2(NREGS)-1:0]        iss_rd,
  output logic [$clog2(NREGS):0]          pend_cnt
);

  localparam int AW = $clog2(NREGS);
  localparam int CW = AW + 1;

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] set_vec;
  logic [NREGS-1:0] clr_vec;
  logic [NREGS-1:0] busy_nxt;
  logic             wa_hit;
  logic             wb_hit;
  logic             iss_hit;
  logic             inc;
  logic             dec_a;
  logic             dec_b;

  assign wa_hit  = wa_en  && (wa_addr != '0);
  assign wb_hit  = wb_en  && (wb_addr != '0);
  assign iss_hit = iss_en && (iss_rd  != '0);

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (iss_hit) set_vec[iss_rd]  = 1'b1;
    if (wa_hit)  clr_vec[wa_addr] = 1'b1;
    if (wb_hit)  clr_vec[wb_addr] = 1'b1;
    // a new producer issued this cycle outranks the retiring one
    busy_nxt = set_vec | (busy & ~clr_vec);
  end

  // Incremental count: one possible rise (issue), up to two falls (one per write port, deduplicated).
  assign inc   = iss_hit && !busy[iss_rd];
  assign dec_a = wa_hit && busy[wa_addr] && !set_vec[wa_addr];
  assign dec_b = wb_hit && busy[wb_addr] && !set_vec[wb_addr] &&
                 !(wa_hit && (wa_addr == wb_addr));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy     <= '0;
      pend_cnt <= '0;
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      busy     <= busy_nxt;
      pend_cnt <= pend_cnt + CW'(inc) - CW'(dec_a) - CW'(dec_b);
      for (int i = 1; i < NREGS; i++) begin
        if (wb_hit && (wb_addr == AW'(i)))      regs[i] <= wb_data;
        else if (wa_hit && (wa_addr == AW'(i))) regs[i] <= wa_data;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a;
    logic          wr_a;
    logic          wr_b;

    assign a    = rd_addr[k*AW +: AW];
    assign wr_a = wa_hit && (wa_addr == a);
    assign wr_b = wb_hit && (wb_addr == a);

    assign rd_busy[k] = busy[a] & ~(wr_a | wr_b);

`ifdef REGFILE_BYPASS_EN
    assign rd_data[k*XLEN +: XLEN] = (a == '0) ? '0      :
                                     wr_b      ? wb_data :
                                     wr_a      ? wa_data : regs[a];
`else
    assign rd_data[k*XLEN +: XLEN] = (a == '0) ? '0 : regs[a];
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: directed scenarios then randomized traffic against an array/queue-level reference model.
module tb_regfile_mp;

  logic        clk;
  logic        rst_n;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        wa_en;
  logic [4:0]  wa_addr;
  logic [31:0] wa_data;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        iss_en;
  logic [4:0]  iss_rd;
  logic [5:0]  pend_cnt;

  regfile_mp dut (
    .clk(clk), .rst_n(rst_n),
    .rd_addr(rd_addr), .rd_data(rd_data), .rd_busy(rd_busy),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .iss_en(iss_en), .iss_rd(iss_rd),
    .pend_cnt(pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  bit          chk_on = 0;
  logic [31:0] m_reg [32];
  bit          m_busy [32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int popcount_busy();
    int c = 0;
    for (int i = 0; i < 32; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  task automatic check_all();
    logic [4:0]  a;
    logic [31:0] exp_d;
    bit          exp_b;
    for (int k = 0; k < 2; k++) begin
      a = rd_addr[k*5 +: 5];
      exp_d = (a == 0) ? 32'h0 : m_reg[a];
`ifdef REGFILE_BYPASS_EN
      if (a != 0 && wb_en && wb_addr == a)      exp_d = wb_data;
      else if (a != 0 && wa_en && wa_addr == a) exp_d = wa_data;
`endif
      exp_b = m_busy[a] && !((wa_en && wa_addr == a) || (wb_en && wb_addr == a));
      chk($sformatf("rd_data[%0d]@x%0d", k, a), rd_data[k*32 +: 32], exp_d);
      chk($sformatf("rd_busy[%0d]@x%0d", k, a), {31'b0, rd_busy[k]}, {31'b0, exp_b});
    end
    chk("pend_cnt", {26'b0, pend_cnt}, popcount_busy());
  endtask

  task automatic model_update();
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        m_reg[i]  = 32'h0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wa_en && wa_addr != 0) m_reg[wa_addr] = wa_data;
      if (wb_en && wb_addr != 0) m_reg[wb_addr] = wb_data;
      if (wa_en && wa_addr != 0) m_busy[wa_addr] = 1'b0;
      if (wb_en && wb_addr != 0) m_busy[wb_addr] = 1'b0;
      if (iss_en && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  endtask

  task automatic step();
    #1;
    if (chk_on) check_all();
    model_update();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    wa_en = 0; wa_addr = 0; wa_data = 0;
    wb_en = 0; wb_addr = 0; wb_data = 0;
    iss_en = 0; iss_rd = 0;
  endtask

  task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
    rd_addr = {a1, a0};
  endtask

  initial begin
    idle();
    rd(5, 0);
    rst_n = 0;
    @(negedge clk);
    // reset must override a concurrent write and issue
    wa_en = 1; wa_addr = 5; wa_data = 32'hDEAD_BEEF;
    iss_en = 1; iss_rd = 5;
    step();
    step();
    rst_n = 1;
    idle();
    chk_on = 1;
    #1;
    chk("reset_x5", rd_data[31:0], 32'h0);
    chk("reset_busy", {30'b0, rd_busy}, 32'h0);
    chk("reset_pend", {26'b0, pend_cnt}, 32'h0);
    step();

    wa_en = 1; wa_addr = 3; wa_data = 32'h1234_5678; rd(3, 0);
    step();
    idle(); rd(3, 0); #1;
    chk("x3_read", rd_data[31:0], 32'h1234_5678);
    wa_en = 1; wa_addr = 0; wa_data = 32'hFFFF_FFFF; rd(0, 0);
    step();
    idle(); rd(0, 3); #1;
    chk("x0_read", rd_data[31:0], 32'h0);

    wa_en = 1; wa_addr = 7; wa_data = 32'hAAAA_AAAA;
    wb_en = 1; wb_addr = 7; wb_data = 32'h5555_5555;
    step();
    idle(); rd(7, 7); #1;
    chk("x7_collision", rd_data[31:0], 32'h5555_5555);
    step();

    iss_en = 1; iss_rd = 9;
    step();
    idle(); rd(9, 0); #1;
    chk("x9_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("pend_after_x9", {26'b0, pend_cnt}, 32'h1);
    iss_en = 1; iss_rd = 10; wa_en = 1; wa_addr = 9; wa_data = 32'h0000_0099; rd(9, 10);
    step();
    idle(); rd(9, 10); #1;
    chk("pend_x9_x10", {26'b0, pend_cnt}, 32'h1);
    chk("x9_idle", {31'b0, rd_busy[0]}, 32'h0);
    chk("x10_busy", {31'b0, rd_busy[1]}, 32'h1);

    iss_en = 1; iss_rd = 4;
    step();
    idle(); #1;
    chk("pend_x4", {26'b0, pend_cnt}, 32'h2);
    iss_en = 1; iss_rd = 4; wb_en = 1; wb_addr = 4; wb_data = 32'h4444_4444; rd(4, 10);
    step();
    idle(); rd(4, 10); #1;
    chk("x4_still_busy", {31'b0, rd_busy[0]}, 32'h1);
    chk("pend_issue_write", {26'b0, pend_cnt}, 32'h2);

    wa_en = 1; wa_addr = 10; wb_en = 1; wb_addr = 4;
    step();
    idle(); iss_en = 1; iss_rd = 2;
    step();
    idle(); iss_en = 1; iss_rd = 6;
    step();
    idle(); rd(2, 6); #1;
    chk("pend_two", {26'b0, pend_cnt}, 32'h2);
    wa_en = 1; wa_addr = 2; wa_data = 32'h2222_2222;
    wb_en = 1; wb_addr = 6; wb_data = 32'h6666_6666;
    step();
    idle(); #1;
    chk("pend_double_retire", {26'b0, pend_cnt}, 32'h0);

    wa_en = 1; wa_addr = 8; wa_data = 32'h1111_1111;
    step();
    wa_en = 1; wa_addr = 8; wa_data = 32'h0BAD_F00D; rd(8, 8); #1;
`ifdef REGFILE_BYPASS_EN
    chk("x8_same_cycle", rd_data[31:0], 32'h0BAD_F00D);
`else
    chk("x8_same_cycle", rd_data[31:0], 32'h1111_1111);
`endif
    step();
    idle(); rd(8, 8); #1;
    chk("x8_next_cycle", rd_data[31:0], 32'h0BAD_F00D);
    step();

    for (int n = 0; n < 800; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      wa_en   = 1'($urandom_range(0, 1));
      wa_addr = 5'($urandom_range(0, 15));
      wa_data = $urandom;
      wb_en   = 1'($urandom_range(0, 1));
      wb_addr = 5'($urandom_range(0, 15));
      wb_data = $urandom;
      iss_en  = ($urandom_range(0, 2) != 0);
      iss_rd  = 5'($urandom_range(0, 15));
      rd(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      step();
    end
    rst_n = 1;
    idle();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
# regfile_mp

Parametrised multi-port integer register file for the RISC-V core, the next generation of the single-write, two-read file. It provides NRD combinational read ports, two prioritised write-back ports (ALU and load), and a per-register pending-write scoreboard with a pending counter. The decode/issue stage uses the scoreboard to stall, and write-back feeds results back into the file.

## Interface
- XLEN, 32: data width in bits.
- NREGS, 32: number of architectural registers; must be a power of two, ≥ 2. Local AW = $clog2(NREGS).
- NRD, 2: number of read ports, 1..4.
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset, synchronous and active-low.
- rd_addr  in  NRD*AW  read addresses; port k occupies [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k occupies [k*XLEN +: XLEN].
- rd_busy  out  NRD  port k's register has a pending write that is not retiring this cycle.
- wa_en, wa_addr, wa_data  in  1, AW, XLEN  write port A (ALU write-back).
- wb_en, wb_addr, wb_data  in  1, AW, XLEN  write port B (load write-back).
- iss_en, iss_rd  in  1, AW  an instruction issued that will write iss_rd.
- pend_cnt  out  AW+1  number of registers currently marked busy.

## Operation
- Storage: NREGS × XLEN flops. Register 0 reads as 0 at all times, is never written and is never busy.
- Writes are committed at the clk edge.
  - Port A writes when wa_en=1 and wa_addr≠0.
  - Port B writes under the same rule for its own signals.
  - If both ports target the same non-zero address in one cycle, port B wins. Port A's data is discarded, but the register's busy bit still clears.
- Reads are combinational from the array. Bypass behaviour is described under Configuration.
- Scoreboard: one busy bit per register.
  - Set on a cycle with iss_en=1 and iss_rd≠0.
  - Cleared on a cycle with an enabled write (A or B) to that address.
  - If a set and a clear hit the same register in the same cycle, the set wins and the bit stays 1, because a new producer is pending.
  - A write to a non-busy register is legal: the data is written and the bit stays 0.
- rd_busy[k] = busy[rd_addr_k] & ~(write to rd_addr_k this cycle). It is combinational and 0 for address 0.
- pend_cnt equals the population count of the busy bits.
  - It is maintained as an up/down counter: +1 for each 0→1 transition, −1 for each 1→0 transition.
  - Per cycle it changes by at most +1 / −2.
  - It is never recomputed by a full popcount. The bench checks it against a reference popcount every cycle.

## Timing
- Reset (rst_n=0 at an edge) clears all registers and busy bits and sets pend_cnt=0, overriding any same-cycle write or issue.
- After reset: rd_data=0 on all ports, rd_busy=0, pend_cnt=0.
- Reset asserted mid-operation discards all pending state. No write-back arriving after the release of reset sets a busy bit.
- Write latency: data written at edge N is visible on rd_data from edge N.
  - With bypass, it is visible combinationally in cycle N−1, the same cycle as the write.
- Issue-to-busy latency: the busy bit is visible on rd_busy the cycle after iss_en.
- An issue and a write to the same register in one cycle leave busy=1 and pend_cnt unchanged.
- There is no backpressure. All inputs are sampled every cycle.

## Configuration
- REGFILE_BYPASS_EN defined:
  - A read of register r ≠ 0 returns the same-cycle write data when a write to r is enabled.
  - Port B data takes precedence when both ports write r.
- REGFILE_BYPASS_EN undefined:
  - Reads return only the array contents, so a same-cycle write is visible one cycle later.
  - rd_busy still excludes the retiring write, so the issue logic must not rely on it to consume data in the same cycle.

## Test plan
- Reset: hold rst_n=0 for 2 cycles with wa_en=1, wa_addr=5, wa_data=32'hDEAD_BEEF → after release all rd_data=0, rd_busy=0, pend_cnt=0, and x5=0.
- Write/read: port A writes x3=32'h1234_5678 → rd_addr port 0 = 3 returns 32'h1234_5678 the next cycle; a write to x0 of 32'hFFFF_FFFF still reads 0.
- Dual-write collision: in one cycle, A writes x7=32'hAAAA_AAAA and B writes x7=32'h5555_5555 → x7 reads 32'h5555_5555.
- Scoreboard:
  - Issue x9 → next cycle rd_busy=1 and pend_cnt=1.
  - Issue x10 in the same cycle that A writes x9 → pend_cnt=1, x9 not busy, x10 busy.
  - Issue x4 while B writes x4 → x4 busy, count unchanged.
- Double retire: x2 and x6 busy (pend_cnt=2), then A writes x2 and B writes x6 in the same cycle → pend_cnt=0 the next cycle.
- Bypass:
  - With REGFILE_BYPASS_EN, reading x8 while writing x8=32'h0BAD_F00D returns 32'h0BAD_F00D in the same cycle.
  - Without the macro, the same stimulus returns the old value, then 32'h0BAD_F00D the next cycle.
